elastic_pipe: RTL and testbench

Parametrised valid/ready pipeline of DEPTH stages. It is the successor to the single-stage forward register.
- Each stage is either a 2-entry skid buffer, which makes in_ready a register output, or a 1-entry forward register, which gives a combinational ready path.
- Adds synchronous flush and an occupancy count.
- Sits between streaming producer and consumer blocks to break long valid/data/ready timing paths.

---
 rtl/elastic_pipe_pkg.sv | 18 +
 rtl/elastic_stage.sv | 133 +++++++++++++
 rtl/elastic_pipe.sv | 83 ++++++++
 tb/tb_elastic_pipe.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elastic_pipe_pkg.sv
// elastic_pipe_pkg: shared types and sizing helpers
// for the elastic valid/ready pipeline.
package elastic_pipe_pkg;

   typedef enum logic [1:0] {
      SK_EMPTY = 2'd0,
      SK_BUSY  = 2'd1,
      SK_FULL  = 2'd2
   } skid_state_e;

   function automatic int pipe_cap(
      input int depth,
      input int reg_ready
   );
      return (reg_ready != 0) ? 2 * depth : depth;
   endfunction

endpackage

// File: rtl/elastic_stage.sv
// elastic_stage: one valid/ready stage, either a
// 2-entry skid buffer or a 1-entry forward register.
module elastic_stage
   import elastic_pipe_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int REG_READY  = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data
);

   logic push;
   logic pop;

   assign push = in_valid && in_ready;
   assign pop  = out_valid && out_ready;

   if (REG_READY != 0) begin : g_skid

      skid_state_e           state_q;
      skid_state_e           state_d;
      logic [DATA_WIDTH-1:0] main_q;
      logic [DATA_WIDTH-1:0] main_d;
      logic [DATA_WIDTH-1:0] skid_q;
      logic [DATA_WIDTH-1:0] skid_d;

      // ready comes only from the state flop
      assign in_ready  = (state_q != SK_FULL) && !flush;
      assign out_valid = (state_q != SK_EMPTY) && !flush;
      assign out_data  = main_q;

      // next state and data-register loads
      always_comb begin
         state_d = state_q;
         main_d  = main_q;
         skid_d  = skid_q;
         if (flush) begin
            state_d = SK_EMPTY;
         end else begin
            unique case (state_q)
               SK_EMPTY: begin
                  if (push) begin
                     state_d = SK_BUSY;
                     main_d  = in_data;
                  end
               end
               SK_BUSY: begin
                  if (push && pop) begin
                     main_d = in_data;
                  end else if (push) begin
                     skid_d  = in_data;
                     state_d = SK_FULL;
                  end else if (pop) begin
                     state_d = SK_EMPTY;
                  end
               end
               SK_FULL: begin
                  if (pop) begin
                     main_d  = skid_q;
                     state_d = SK_BUSY;
                  end
               end
               default: state_d = SK_EMPTY;
            endcase
         end
      end

      // state register
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state_q <= SK_EMPTY;
         end else begin
            state_q <= state_d;
         end
      end

      // payload registers carry no reset
      always_ff @(posedge clk) begin
         main_q <= main_d;
         skid_q <= skid_d;
      end

   end else begin : g_fwd

      logic                  valid_q;
      logic                  valid_d;
      logic [DATA_WIDTH-1:0] data_q;
      logic [DATA_WIDTH-1:0] data_d;

      // ready passes straight through from downstream
      assign in_ready  = (!valid_q || out_ready) && !flush;
      assign out_valid = valid_q && !flush;
      assign out_data  = data_q;

      // valid tracking and data load
      always_comb begin
         valid_d = valid_q;
         data_d  = data_q;
         if (flush) begin
            valid_d = 1'b0;
         end else if (push) begin
            valid_d = 1'b1;
            data_d  = in_data;
         end else if (pop) begin
            valid_d = 1'b0;
         end
      end

      // valid register
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            valid_q <= 1'b0;
         end else begin
            valid_q <= valid_d;
         end
      end

      // payload register carries no reset
      always_ff @(posedge clk) begin
         data_q <= data_d;
      end

   end

endmodule

// File: rtl/elastic_pipe.sv
// elastic_pipe: DEPTH cascaded elastic stages with
// synchronous flush and a registered occupancy count.
module elastic_pipe
   import elastic_pipe_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 2,
   parameter int REG_READY  = 1,
   localparam int CAP       = pipe_cap(DEPTH, REG_READY),
   localparam int OCC_W     = $clog2(CAP + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [OCC_W-1:0]      occupancy
);

   logic                  vld [DEPTH+1];
   logic                  rdy [DEPTH+1];
   logic [DATA_WIDTH-1:0] dat [DEPTH+1];

   logic             in_xfer;
   logic             out_xfer;
   logic [OCC_W-1:0] occ_q;
   logic [OCC_W-1:0] occ_d;

   assign vld[0]   = in_valid;
   assign dat[0]   = in_data;
   assign in_ready = rdy[0];

   assign out_valid  = vld[DEPTH];
   assign out_data   = dat[DEPTH];
   assign rdy[DEPTH] = out_ready;

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      elastic_stage #(
         .DATA_WIDTH (DATA_WIDTH),
         .REG_READY  (REG_READY)
      ) u_stage (
         .clk       (clk),
         .rst_n     (rst_n),
         .flush     (flush),
         .in_valid  (vld[k]),
         .in_ready  (rdy[k]),
         .in_data   (dat[k]),
         .out_valid (vld[k+1]),
         .out_ready (rdy[k+1]),
         .out_data  (dat[k+1])
      );
   end

   assign in_xfer  = in_valid && in_ready;
   assign out_xfer = out_valid && out_ready;

   // occupancy tracks boundary transfers
   always_comb begin
      occ_d = occ_q;
      unique case (1'b1)
         flush:                 occ_d = '0;
         in_xfer && !out_xfer:  occ_d = occ_q + OCC_W'(1);
         !in_xfer && out_xfer:  occ_d = occ_q - OCC_W'(1);
         default:               occ_d = occ_q;
      endcase
   end

   // occupancy register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_q <= '0;
      end else begin
         occ_q <= occ_d;
      end
   end

   assign occupancy = occ_q;

endmodule

// File: tb/tb_elastic_pipe.sv
// tb_elastic_pipe: directed and randomised checks of
// elastic_pipe across skid and forward configurations.
module tb_elastic_pipe;

   localparam int NI = 6;
   localparam int DEP [NI] = '{2, 3, 2, 1, 1, 3};
   localparam int RR  [NI] = '{1, 1, 0, 0, 1, 0};

   logic        clk = 1'b0;
   logic        rst_n;
   logic        iv   [NI];
   logic        irdy [NI];
   logic [31:0] id   [NI];
   logic        ov   [NI];
   logic        ordy [NI];
   logic [31:0] od   [NI];
   logic        fl   [NI];
   logic [7:0]  occ  [NI];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int CAPG = (RR[g] != 0) ? 2 * DEP[g] : DEP[g];
      localparam int OW   = $clog2(CAPG + 1);
      logic [OW-1:0] occ_w;
      elastic_pipe #(
         .DATA_WIDTH (32),
         .DEPTH      (DEP[g]),
         .REG_READY  (RR[g])
      ) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .flush     (fl[g]),
         .in_valid  (iv[g]),
         .in_ready  (irdy[g]),
         .in_data   (id[g]),
         .out_valid (ov[g]),
         .out_ready (ordy[g]),
         .out_data  (od[g]),
         .occupancy (occ_w)
      );
      assign occ[g] = 8'(occ_w);
   end

   task automatic chk(
      input string       tag,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int  n_acc;
      int  n_pop;
      int  first_push;
      int  first_pop;
      int  last_pop;
      int  rdy_at;
      bit  seen;
      bit  rdy_ok;
      int  in_cnt  [NI];
      int  out_cnt [NI];

      for (int i = 0; i < NI; i++) begin
         iv[i]   = 1'b0;
         ordy[i] = 1'b0;
         fl[i]   = 1'b0;
         id[i]   = '0;
      end
      rst_n = 1'b0;
      cyc();
      cyc();
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("rst_irdy%0d", i), 32'(irdy[i]), 1);
         chk($sformatf("rst_ov%0d", i), 32'(ov[i]), 0);
         chk($sformatf("rst_occ%0d", i), 32'(occ[i]), 0);
      end
      rst_n = 1'b1;

      // reset mid-operation on D2 skid
      for (int k = 0; k < 3; k++) begin
         iv[0] = 1'b1;
         id[0] = 32'h100 + k;
         #1;
         chk("t1_load_rdy", 32'(irdy[0]), 1);
         cyc();
      end
      iv[0] = 1'b0;
      #1;
      chk("t1_occ3", 32'(occ[0]), 3);
      #1;
      rst_n = 1'b0;
      #1;
      chk("t1_rst_ov", 32'(ov[0]), 0);
      chk("t1_rst_occ", 32'(occ[0]), 0);
      chk("t1_rst_irdy", 32'(irdy[0]), 1);
      cyc();
      rst_n   = 1'b1;
      ordy[0] = 1'b1;
      seen    = 1'b0;
      for (int k = 0; k < 8; k++) begin
         #1;
         if (ov[0]) seen = 1'b1;
         cyc();
      end
      chk("t1_no_pulse", 32'(seen), 0);
      ordy[0] = 1'b0;

      // streaming through D3 skid
      n_acc      = 0;
      n_pop      = 0;
      first_push = -1;
      first_pop  = -1;
      last_pop   = -1;
      rdy_ok     = 1'b1;
      ordy[1]    = 1'b1;
      for (int c = 0; c < 40; c++) begin
         iv[1] = (n_acc < 16);
         id[1] = 32'(n_acc + 1);
         #1;
         if (iv[1] && !irdy[1]) rdy_ok = 1'b0;
         if (ov[1] && ordy[1]) begin
            if (first_pop < 0) first_pop = c;
            last_pop = c;
            chk("t2_data", od[1], 32'(n_pop + 1));
            n_pop++;
            if (n_pop == 1 || n_pop == 8)
               chk("t2_occ", 32'(occ[1]), 3);
         end
         if (iv[1] && irdy[1]) begin
            if (first_push < 0) first_push = c;
            n_acc++;
         end
         cyc();
      end
      iv[1] = 1'b0;
      chk("t2_latency", 32'(first_pop - first_push), 3);
      chk("t2_back2back", 32'(last_pop - first_pop), 15);
      chk("t2_count", 32'(n_pop), 16);
      chk("t2_rdy_high", 32'(rdy_ok), 1);

      // backpressure on D2 skid
      ordy[0] = 1'b0;
      n_acc   = 0;
      for (int c = 0; c < 8; c++) begin
         iv[0] = 1'b1;
         id[0] = 32'h11 + n_acc;
         #1;
         if (iv[0] && irdy[0]) n_acc++;
         cyc();
      end
      #1;
      chk("t3_accepted", 32'(n_acc), 4);
      chk("t3_irdy_low", 32'(irdy[0]), 0);
      chk("t3_occ4", 32'(occ[0]), 4);
      ordy[0] = 1'b1;
      iv[0]   = 1'b0;
      n_pop   = 0;
      rdy_at  = -1;
      for (int c = 0; c < 12; c++) begin
         #1;
         if (irdy[0] && rdy_at < 0) rdy_at = c;
         if (ov[0] && ordy[0]) begin
            chk("t3_order", od[0], 32'h11 + n_pop);
            n_pop++;
         end
         cyc();
      end
      chk("t3_rdy_lat", 32'(rdy_at >= 0 && rdy_at <= 2), 1);
      chk("t3_drained", 32'(n_pop), 4);

      // combinational ready on D2 forward
      ordy[2] = 1'b0;
      n_acc   = 0;
      for (int c = 0; c < 5; c++) begin
         iv[2] = 1'b1;
         id[2] = 32'h40 + n_acc;
         #1;
         if (irdy[2]) n_acc++;
         cyc();
      end
      #1;
      chk("t4_accepted", 32'(n_acc), 2);
      chk("t4_irdy_low", 32'(irdy[2]), 0);
      chk("t4_occ2", 32'(occ[2]), 2);
      ordy[2] = 1'b1;
      #1;
      chk("t4_comb_rdy", 32'(irdy[2]), 1);
      chk("t4_pop0", od[2], 32'h40);
      cyc();
      iv[2] = 1'b0;
      #1;
      chk("t4_occ_hold", 32'(occ[2]), 2);
      chk("t4_pop1", od[2], 32'h41);
      for (int c = 0; c < 4; c++) cyc();
      chk("t4_empty", 32'(occ[2]), 0);
      ordy[2] = 1'b0;

      // flush on D2 skid with three words held
      ordy[0] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         iv[0] = 1'b1;
         id[0] = 32'h50 + k;
         cyc();
      end
      iv[0] = 1'b0;
      #1;
      chk("t5_occ3", 32'(occ[0]), 3);
      fl[0]   = 1'b1;
      iv[0]   = 1'b1;
      ordy[0] = 1'b1;
      id[0]   = 32'h5f;
      #1;
      chk("t5_fl_irdy", 32'(irdy[0]), 0);
      chk("t5_fl_ov", 32'(ov[0]), 0);
      cyc();
      fl[0] = 1'b0;
      iv[0] = 1'b0;
      #1;
      chk("t5_occ0", 32'(occ[0]), 0);
      chk("t5_ov0", 32'(ov[0]), 0);
      iv[0] = 1'b1;
      id[0] = 32'haa;
      cyc();
      iv[0] = 1'b0;
      n_pop = 0;
      for (int c = 0; c < 6; c++) begin
         #1;
         if (ov[0] && ordy[0]) begin
            if (n_pop == 0) chk("t5_first", od[0], 32'haa);
            n_pop++;
         end
         cyc();
      end
      chk("t5_one_out", 32'(n_pop), 1);
      ordy[0] = 1'b0;

      // random traffic on D1/D3, both modes
      for (int i = 0; i < NI; i++) begin
         in_cnt[i]  = 0;
         out_cnt[i] = 0;
      end
      for (int c = 0; c < 10000; c++) begin
         for (int i = 1; i < NI; i++) begin
            if (i != 2) begin
               fl[i]   = ($urandom_range(0, 99) < 5);
               iv[i]   = ($urandom_range(0, 3) != 0);
               ordy[i] = ($urandom_range(0, 1) != 0);
               id[i]   = 32'(in_cnt[i]);
            end
         end
         #1;
         for (int i = 1; i < NI; i++) begin
            if (i != 2) begin
               if (fl[i]) begin
                  chk($sformatf("r_flush_hs%0d", i),
                      32'({irdy[i], ov[i]}), 0);
               end else begin
                  if (ov[i] && ordy[i]) begin
                     chk($sformatf("r_data%0d", i),
                         od[i], 32'(out_cnt[i]));
                     out_cnt[i]++;
                  end
                  if (iv[i] && irdy[i]) in_cnt[i]++;
               end
            end
         end
         cyc();
         for (int i = 1; i < NI; i++) begin
            if (i != 2) begin
               if (fl[i]) out_cnt[i] = in_cnt[i];
               chk($sformatf("r_occ%0d", i), 32'(occ[i]),
                   32'(in_cnt[i] - out_cnt[i]));
            end
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
